// File: rtl/coleta_votos_pkg.sv
// coleta_votos_pkg: shared state encoding, limits and width helper for the vote collector.
package coleta_votos_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_SEND} state_t;

    localparam int MAX_VOTERS = 8;

    function automatic int idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coleta_votos_timeout.sv
// contador_timeout: loadable down-counter that stops at zero and flags it.
module contador_timeout #(
    parameter int TIMEOUT_CYC = 1000,
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (load_i)
            r_cnt <= TW'(TIMEOUT_CYC - 1);
        else if (dec_i && r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign zero_o = (r_cnt == '0);

endmodule

// File: rtl/coleta_votos.sv
// coleta_votos: collects one yes/no vote per voter per session and hands the
// ballot vector to the vote counter over a valid/ready handshake.
module coleta_votos
    import coleta_votos_pkg::*;
#(
    parameter int N_VOTERS    = 3,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start_i,
    input  logic                      vote_valid_i,
    input  logic [idw(N_VOTERS)-1:0]  vote_id_i,
    input  logic                      vote_val_i,
    output logic                      vote_ready_o,
    output logic [N_VOTERS-1:0]       v_o,
    output logic                      v_valid_o,
    input  logic                      v_ready_i,
    output logic [N_VOTERS-1:0]       voted_o,
    output logic                      busy_o,
    output logic                      vote_err_o,
    output logic                      timeout_o
);

    localparam int IDW = idw(N_VOTERS);

    state_t                r_state, w_state_nx;
    logic [N_VOTERS-1:0]   r_ballot, r_voted, w_onehot, w_voted_nx;
    logic                  w_offer, w_free, w_acc, w_done, w_zero, w_load;

    assign w_onehot   = N_VOTERS'(1) << vote_id_i;
    assign w_offer    = vote_valid_i & vote_ready_o;
    // An out-of-range id shifts the one-hot to zero, so the range test is explicit.
    assign w_free     = (int'(vote_id_i) < N_VOTERS) && ((r_voted & w_onehot) == '0);
    assign w_acc      = w_offer & w_free;
    assign w_voted_nx = r_voted | (w_acc ? w_onehot : '0);
    assign w_done     = &w_voted_nx;
    assign w_load     = (r_state == ST_IDLE) && start_i;

    contador_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (w_load),
        .dec_i  (r_state == ST_OPEN),
        .zero_o (w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx   = r_state;
        vote_ready_o = 1'b0;
        v_valid_o    = 1'b0;
        busy_o       = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: if (start_i) w_state_nx = ST_OPEN;
            ST_OPEN: begin
                vote_ready_o = 1'b1;
                if (w_done || w_zero) w_state_nx = ST_SEND;
            end
            ST_SEND: begin
                v_valid_o = 1'b1;
                if (v_ready_i) w_state_nx = ST_IDLE;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ballot   <= '0;
            r_voted    <= '0;
            vote_err_o <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            vote_err_o <= w_offer & ~w_free;
            if (w_load) begin
                r_ballot  <= '0;
                r_voted   <= '0;
                timeout_o <= 1'b0;
            end else if (w_acc) begin
                r_ballot <= r_ballot | (vote_val_i ? w_onehot : '0);
                r_voted  <= w_voted_nx;
            end
            // Completion in the final cycle takes priority over timeout.
            if (r_state == ST_OPEN && w_zero && !w_done)
                timeout_o <= 1'b1;
        end
    end

    assign v_o     = r_ballot;
    assign voted_o = r_voted;

endmodule
